// File: rtl/icache_dm_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
// Address layout: {tag, index, word, byte}.
package icache_types;

  typedef enum logic [1:0] {
    IDLE,
    LOOKUP,
    MISS
  } state_t;

  localparam int OFFSET_W   = 5;
  localparam int WORD_SEL_W = 3;

  function automatic int idx_w(input int sets);
    return $clog2(sets);
  endfunction

  function automatic int tag_w(input int sets);
    return 32 - OFFSET_W - $clog2(sets);
  endfunction

endpackage

// File: rtl/icache_dm_control.sv
// Cache controller FSM: request latch, tag lookup, line refill.
// Outputs decode from state so reset drops them asynchronously.
module icache_control
  import icache_types::*;
(
  input  logic clk,
  input  logic rst,
  input  logic imem_read,
  input  logic hit,
  input  logic pmem_resp,
  output logic latch_req,
  output logic load_line,
  output logic imem_resp,
  output logic pmem_read
);

  state_t state;
  state_t state_nxt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    latch_req = 1'b0;
    load_line = 1'b0;
    imem_resp = 1'b0;
    pmem_read = 1'b0;
    unique case (state)
      IDLE: begin
        if (imem_read) begin
          latch_req = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      LOOKUP: begin
        if (hit) begin
          imem_resp = 1'b1;
          state_nxt = IDLE;
        end else begin
          state_nxt = MISS;
        end
      end
      MISS: begin
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_line = 1'b1;
          state_nxt = LOOKUP;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/icache_dm.sv
// Read-only direct-mapped instruction cache with flop-based storage.
// Tags and data are left unreset; only valid bits gate hits.
module icache_dm
  import icache_types::*;
#(
  parameter int NUM_SETS  = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 imem_read,
  input  logic [31:0]          imem_address,
  output logic                 imem_resp,
  output logic [31:0]          imem_rdata,
  output logic                 pmem_read,
  output logic [31:0]          pmem_address,
  input  logic [LINE_BITS-1:0] pmem_rdata,
  input  logic                 pmem_resp
);

  localparam int IDX_W = idx_w(NUM_SETS);
  localparam int TAG_W = tag_w(NUM_SETS);

  logic [31:0]           req_addr;
  logic [NUM_SETS-1:0]   valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_SETS];
  logic [LINE_BITS-1:0]  data_q [NUM_SETS];

  logic [IDX_W-1:0]      req_idx;
  logic [TAG_W-1:0]      req_tag;
  logic [WORD_SEL_W-1:0] req_word;
  logic [LINE_BITS-1:0]  line_sel;
  logic [31:0]           word_sel;
  logic                  hit;
  logic                  latch_req;
  logic                  load_line;
  logic                  unused_bits;

  assign req_idx     = req_addr[OFFSET_W +: IDX_W];
  assign req_tag     = req_addr[31 -: TAG_W];
  assign req_word    = req_addr[2 +: WORD_SEL_W];
  assign unused_bits = ^req_addr[1:0];

  assign hit      = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign line_sel = data_q[req_idx];
  assign word_sel = line_sel[{req_word, 5'd0} +: 32];

  assign imem_rdata   = hit ? word_sel : 32'd0;
  assign pmem_address = pmem_read ? {req_tag, req_idx, 5'd0} : 32'd0;

  icache_control u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .imem_read (imem_read),
    .hit       (hit),
    .pmem_resp (pmem_resp),
    .latch_req (latch_req),
    .load_line (load_line),
    .imem_resp (imem_resp),
    .pmem_read (pmem_read)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_addr <= 32'd0;
      valid_q  <= '0;
    end else begin
      if (latch_req) req_addr <= imem_address;
      if (load_line) valid_q[req_idx] <= 1'b1;
    end
  end

  // Refill only fires from MISS, so stray or abandoned responses never land.
  always_ff @(posedge clk) begin
    if (load_line) begin
      tag_q[req_idx]  <= req_tag;
      data_q[req_idx] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache_dm.sv
// Scoreboard bench for icache_dm: directed fetches, pmem model, monitor.
module tb_icache_dm;

  logic         clk = 1'b0;
  logic         rst;
  logic         imem_read;
  logic [31:0]  imem_address;
  logic         imem_resp;
  logic [31:0]  imem_rdata;
  logic         pmem_read;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;

  int tests = 0;
  int fails = 0;
  int refills = 0;
  int pcnt = 0;
  bit pmem_en = 1'b1;
  logic [31:0] exp_pa = 32'd0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  icache_dm dut (
    .clk          (clk),
    .rst          (rst),
    .imem_read    (imem_read),
    .imem_address (imem_address),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .pmem_read    (pmem_read),
    .pmem_address (pmem_address),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp)
  );

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [255:0] mk_line(input logic [31:0] pa);
    logic [255:0] l;
    logic [31:0]  b;
    b = 32'h1000_0000 + ((pa & 32'h0000_FFFF) << 8);
    for (int k = 0; k < 8; k++) l[k*32 +: 32] = b + k;
    return l;
  endfunction

  // pmem model: answers on the 5th MISS cycle with a line derived from the address
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (pmem_en) begin
        pmem_resp = 1'b0;
        if (pmem_read) begin
          pcnt++;
          check("pmem_address", pmem_address, exp_pa);
          if (pcnt == 5) begin
            pmem_rdata = mk_line(pmem_address);
            pmem_resp  = 1'b1;
            refills++;
            pcnt = 0;
          end
        end else begin
          pcnt = 0;
          if (!rst) check("pmem_address_idle", pmem_address, 32'd0);
        end
      end
    end
  end

  // monitor: every imem_resp must match the oldest outstanding expectation
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (imem_resp) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_resp: got rdata %h with no request outstanding",
                   imem_rdata);
        end else begin
          e = exp_q.pop_front();
          check("imem_rdata", imem_rdata, e);
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a, input logic [31:0] alt,
                       input logic [31:0] pa, input logic [31:0] exp_data,
                       input int exp_refills);
    int n;
    int r0;
    @(posedge clk);
    #1;
    r0 = refills;
    exp_pa = pa;
    exp_q.push_back(exp_data);
    imem_address = a;
    imem_read = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (pmem_read) imem_address = alt;
    end while (!imem_resp && n < 200);
    check("resp_seen", {31'd0, imem_resp}, 32'd1);
    check("latency", n, (exp_refills != 0) ? 32'd8 : 32'd2);
    @(posedge clk);
    #1;
    imem_read = 1'b0;
    check("refills", refills - r0, exp_refills);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    imem_read = 1'b0;
    imem_address = 32'd0;
    repeat (3) @(negedge clk);
    check("rst_imem_resp", {31'd0, imem_resp}, 32'd0);
    check("rst_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("rst_pmem_addr", pmem_address, 32'd0);
    rst = 1'b0;

    fetch(32'h6000_0000, 32'h6000_0000, 32'h6000_0000, 32'h1000_0000, 1);
    fetch(32'h6000_001C, 32'h6000_001C, 32'h6000_0000, 32'h1000_0007, 0);
    fetch(32'h6000_0008, 32'h6000_0008, 32'h6000_0000, 32'h1000_0002, 0);
    fetch(32'h6000_0200, 32'h6000_0200, 32'h6000_0200, 32'h1002_0000, 1);
    fetch(32'h6000_0000, 32'h6000_0000, 32'h6000_0000, 32'h1000_0000, 1);
    fetch(32'h6000_0040, 32'h6000_0080, 32'h6000_0040, 32'h1000_4000, 1);
    fetch(32'h6000_0080, 32'h6000_0080, 32'h6000_0080, 32'h1000_8000, 1);
    fetch(32'h6000_01E0, 32'h6000_01E0, 32'h6000_01E0, 32'h1001_E000, 1);
    fetch(32'h6000_01FC, 32'h6000_01FC, 32'h6000_01E0, 32'h1001_E007, 0);
    fetch(32'h6000_0004, 32'h6000_0004, 32'h6000_0000, 32'h1000_0001, 0);

    // reset while refilling 0x6000_0100, then a late pmem_resp
    pmem_en = 1'b0;
    @(posedge clk);
    #1;
    imem_address = 32'h6000_0100;
    imem_read = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!pmem_read && n < 50);
    check("midrst_in_miss", {31'd0, pmem_read}, 32'd1);
    check("midrst_pmem_addr", pmem_address, 32'h6000_0100);
    #2;
    rst = 1'b1;
    imem_read = 1'b0;
    #1;
    check("midrst_pmem_read", {31'd0, pmem_read}, 32'd0);
    check("midrst_imem_resp", {31'd0, imem_resp}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    pmem_rdata = {8{32'hDEAD_BEEF}};
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("late_resp_pmem_read", {31'd0, pmem_read}, 32'd0);
    repeat (2) @(negedge clk);
    pmem_en = 1'b1;
    fetch(32'h6000_0100, 32'h6000_0100, 32'h6000_0100, 32'h1001_0000, 1);
    fetch(32'h6000_001C, 32'h6000_001C, 32'h6000_0000, 32'h1000_0007, 1);

    // stray pmem_resp while idle
    @(negedge clk);
    pmem_en = 1'b0;
    pmem_rdata = {8{32'hFFFF_FFFF}};
    pmem_resp = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b0;
    check("stray_pmem_read", {31'd0, pmem_read}, 32'd0);
    pmem_en = 1'b1;
    fetch(32'h6000_0104, 32'h6000_0104, 32'h6000_0100, 32'h1001_0001, 0);
    fetch(32'h6000_0018, 32'h6000_0018, 32'h6000_0000, 32'h1000_0006, 0);
    fetch(32'h6000_0060, 32'h6000_0060, 32'h6000_0060, 32'h1000_6000, 1);

    repeat (3) @(negedge clk);
    check("queue_drained", exp_q.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/icache_dm.md
Name: icache_dm

Overview:
- Read-only, direct-mapped instruction cache.
- Sits between the fetch stage and the physical-memory line interface.
- Answers fetch requests on imem_read/imem_address with imem_resp/imem_rdata.
- Refills whole 256-bit lines from pmem on a miss.

Parameters:
- NUM_SETS, 16, number of lines; power of two, at least 2; index width is log2(NUM_SETS).
- LINE_BITS, 256, line width; fixed 32-byte line, 8 words, 5-bit offset.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- imem_read  input  1  fetch request valid; held high until imem_resp.
- imem_address  input  32  fetch byte address; bits [1:0] ignored.
- imem_resp  output  1  one-cycle pulse; imem_rdata is valid this cycle.
- imem_rdata  output  32  instruction word for the latched request.
- pmem_read  output  1  line-refill request; held until pmem_resp.
- pmem_address  output  32  line-aligned refill address, {tag, index, 5'b0}.
- pmem_rdata  input  256  refill line; word k occupies bits [32k+31:32k].
- pmem_resp  input  1  one-cycle pulse; pmem_rdata is valid this cycle.

Behaviour:
- Address split:
  - word = addr[4:2]
  - index = addr[4+log2(NUM_SETS):5]
  - tag = addr[31:5+log2(NUM_SETS)]
- Storage per set: valid bit, tag, 256-bit data. All three are flops; no memory macro.
- Request register req_addr is latched in IDLE when imem_read=1.
  - The response always corresponds to req_addr.
  - Changes on imem_address after latching are ignored until the next IDLE.
- States and transitions:
  - IDLE: imem_resp=0, pmem_read=0. If imem_read, latch req_addr and go to LOOKUP; else stay.
  - LOOKUP: hit = valid[index] && tag match.
    - On hit: imem_resp=1 combinationally this cycle, imem_rdata = data[index] word, go to IDLE.
    - On miss: go to MISS; imem_resp=0.
  - MISS: pmem_read=1, pmem_address={req tag, req index, 5'b0}, stable for the whole state.
    - On pmem_resp: write data[index]=pmem_rdata, tag[index]=req tag, valid[index]=1, then go to LOOKUP.
    - Otherwise stay in MISS.
- Latency:
  - Hit: imem_resp 1 cycle after the request is first seen in IDLE (request in IDLE, response in LOOKUP).
  - Miss: 1 cycle, plus refill wait, plus 1 cycle (MISS, then LOOKUP re-hit).
  - Throughput: at most one response per 2 cycles.
- Outputs when not asserted: imem_rdata is don't-care but must be X-free; drive the selected word or 0. pmem_address is 0 outside MISS.
- Boundary conditions:
  - pmem_resp outside MISS is ignored; no array write occurs.
  - Miss to an occupied set replaces the line unconditionally; no write-back (read-only).
  - imem_read dropping during MISS: the refill still completes and the line is installed. LOOKUP then issues imem_resp anyway; the requester may ignore it.
  - Word 7 of a line (addr[4:2]=7) selects bits [255:224].
  - Top set (index NUM_SETS-1) behaves identically; there is no wrap into neighbouring sets.
- Reset (asynchronous, any state, including mid-MISS):
  - state=IDLE, all valid=0, req_addr=0.
  - imem_resp=0 and pmem_read=0 immediately.
  - Tags and data are not reset.
  - A pmem_resp for an abandoned refill is ignored.

Decomposition:
- Package icache_types holds:
  - state enum {IDLE, LOOKUP, MISS}
  - constants OFFSET_W=5, WORD_SEL_W=3
  - localparam-style functions for index and tag widths
- Sub-module icache_control holds the FSM, next-state logic and output decode. Its inputs are hit, imem_read and pmem_resp. Its outputs are latch_req, load_line, imem_resp and pmem_read.
- Arrays, tag compare and word select stay in icache_dm.

Test Plan:
- Cold miss:
  - Stimulus: after reset, imem_read=1, imem_address=0x6000_0000; pmem answers after 5 cycles with line word k = 0x1000_0000+k.
  - Response: pmem_read high with pmem_address=0x6000_0000 until pmem_resp; imem_resp one cycle later with imem_rdata=0x1000_0000.
- Hit and word select:
  - Stimulus: after the above, request 0x6000_001C.
  - Response: no pmem_read; imem_resp 1 cycle after request with rdata=0x1000_0007. Request 0x6000_0008 returns 0x1000_0002.
- Conflict eviction:
  - Stimulus: request 0x6000_0200 (same index 0, NUM_SETS=16, different tag).
  - Response: miss and refill from 0x6000_0200. A following request to 0x6000_0000 misses again.
- Address change mid-miss:
  - Stimulus: request 0x6000_0040, then switch imem_address to 0x6000_0080 during MISS.
  - Response: pmem_address stays 0x6000_0040; the response carries word 0 of that line.
- Reset mid-refill:
  - Stimulus: assert rst while in MISS; pmem_resp arrives 2 cycles later.
  - Response: pmem_read drops asynchronously; no imem_resp. A subsequent request to the same address misses (valid cleared).
- Stray pmem_resp:
  - Stimulus: pulse pmem_resp while in IDLE.
  - Response: no state change, and all valid bits unchanged.
